// File: rtl/pc_seq_pkg.sv
// Shared widths, opcode and state encodings for the fetch/redirect sequencer.
package pc_seq_pkg;

  localparam int INSTR_W     = 8;
  localparam int PC_W        = 4;
  localparam int STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    OP_SEQ  = 3'b000,
    OP_JMP  = 3'b001,
    OP_JZ   = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100,
    OP_HALT = 3'b101
  } opcode_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO; a push when full or a pop when empty is dropped.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int W     = PC_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 top,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign depth = count;
  assign top   = mem[AW'(count - 1'b1)];

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + 1'b1;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[AW'(count)] <= wdata;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Two-phase fetch/execute controller driving program_counter load/next_pc.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int STACK_DEPTH = pc_seq_pkg::STACK_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PC_W-1:0]                    pc,
  input  logic                               zero_flag,
  output logic                               imem_req,
  output logic [PC_W-1:0]                    imem_addr,
  input  logic                               imem_ack,
  input  logic [INSTR_W-1:0]                 imem_data,
  output logic                               load,
  output logic [PC_W-1:0]                    next_pc,
  output logic                               exec_valid,
  output logic                               halted,
  output logic                               stack_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);

  state_t          state, state_nxt;
  logic [2:0]      ir_op;
  logic [PC_W-1:0] ir_tgt;
  logic            push, pop, err_set;
  logic [PC_W-1:0] stk_top;
  logic            stk_full, stk_empty;
  logic            unused_imem_bit;

  assign unused_imem_bit = imem_data[4];
  assign imem_addr       = pc;

  ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (pc + PC_W'(1)),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .depth (depth)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      ir_op  <= '0;
      ir_tgt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ack) begin
        ir_op  <= imem_data[INSTR_W-1 -: 3];
        ir_tgt <= imem_data[PC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_err <= 1'b0;
    end else if (err_set) begin
      stack_err <= 1'b1;
    end
  end

  // Default is "hold the PC"; only EXEC ever lets it increment or redirects it.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_nxt  = state;
    imem_req   = 1'b0;
    load       = 1'b1;
    next_pc    = pc;
    exec_valid = 1'b0;
    halted     = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        exec_valid = 1'b1;
        state_nxt  = S_FETCH;
        case (opcode_t'(ir_op))
          OP_JMP: next_pc = ir_tgt;
          OP_JZ: begin
            if (zero_flag) next_pc = ir_tgt;
            else           load    = 1'b0;
          end
          OP_CALL: begin
            next_pc = ir_tgt;
            if (stk_full) err_set = 1'b1;
            else          push    = 1'b1;
          end
          OP_RET: begin
            if (stk_empty) begin
              err_set = 1'b1;
              load    = 1'b0;
            end else begin
              pop     = 1'b1;
              next_pc = stk_top;
            end
          end
          OP_HALT: state_nxt = S_HALT;
          default: load = 1'b0;
        endcase
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench: sequencer + behavioural program counter + ROM with per-address ack delay.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pc;
  logic       zero_flag = 1'b0;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic       load;
  logic [3:0] next_pc;
  logic       exec_valid;
  logic       halted;
  logic       stack_err;
  logic [2:0] depth;

  int errors = 0;
  int checks = 0;
  int n_exec;

  logic [7:0] rom [16];
  int         dly [16];
  int         wait_cnt = 0;

  // ISA-level reference state
  int m_pc;
  int stk[$];
  bit m_err;
  bit m_halt;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .zero_flag(zero_flag),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .load(load), .next_pc(next_pc),
    .exec_valid(exec_valid), .halted(halted), .stack_err(stack_err),
    .depth(depth)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pc <= 4'd0;
    else if (load) pc <= next_pc;
    else           pc <= pc + 4'd1;
  end

  // ROM: ack after dly[addr] wait cycles; random noise on ack/data when not requested.
  always @(negedge clk) begin
    if (!rst_n) begin
      wait_cnt  = 0;
      imem_ack  = 1'b0;
      imem_data = 8'($urandom);
    end else if (imem_req) begin
      if (wait_cnt >= dly[imem_addr]) begin
        imem_ack  = 1'b1;
        imem_data = rom[imem_addr];
      end else begin
        imem_ack  = 1'b0;
        imem_data = 8'($urandom);
        wait_cnt++;
      end
    end else begin
      imem_ack  = 1'($urandom);
      imem_data = 8'($urandom);
      wait_cnt  = 0;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'h00;
      dly[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [7:0] w;
    int op, tgt, nxt;
    w   = rom[m_pc];
    op  = int'(w[7:5]);
    tgt = int'(w[3:0]);
    nxt = (m_pc + 1) % 16;
    case (op)
      1: nxt = tgt;
      2: if (zero_flag) nxt = tgt;
      3: begin
        if (stk.size() < 4) stk.push_back((m_pc + 1) % 16);
        else                m_err = 1'b1;
        nxt = tgt;
      end
      4: begin
        if (stk.size() == 0) m_err = 1'b1;
        else                 nxt = stk.pop_back();
      end
      5: begin
        nxt    = m_pc;
        m_halt = 1'b1;
      end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  task automatic do_reset();
    @(negedge clk); #3 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); #3 rst_n = 1'b1;
  endtask

  task automatic run_prog(input int n);
    int cyc;
    bit got;
    m_pc = 0; stk.delete(); m_err = 1'b0; m_halt = 1'b0; n_exec = 0;
    do_reset();
    cyc = 0;
    for (int i = 0; i < n && !m_halt; i++) begin
      got = 1'b0;
      while (!got) begin
        @(negedge clk); #1;
        if (exec_valid) begin
          got = 1'b1;
        end else begin
          cyc++;
          checks++;
          if (imem_req !== 1'b1 || imem_addr !== pc || load !== 1'b1 ||
              next_pc !== pc || pc !== 4'(m_pc)) begin
            errors++;
            $display("FAIL fetch_hold req=%b addr=%h load=%b next_pc=%h pc=%h required req=1 addr=pc load=1 next_pc=pc pc=%h",
                     imem_req, imem_addr, load, next_pc, pc, 4'(m_pc));
          end
          if (cyc > 40) begin
            checks++; errors++;
            $display("FAIL fetch_timeout pc=%h no exec_valid within 40 cycles", pc);
            return;
          end
        end
      end
      n_exec++;
      checks++;
      if (pc !== 4'(m_pc) || imem_req !== 1'b0 || cyc != dly[m_pc] + 1) begin
        errors++;
        $display("FAIL exec_entry pc=%h req=%b fetch_cycles=%0d required pc=%h req=0 fetch_cycles=%0d",
                 pc, imem_req, cyc, 4'(m_pc), dly[m_pc] + 1);
      end
      model_step();
      @(negedge clk); #1;
      checks++;
      if (pc !== 4'(m_pc) || depth !== 3'(stk.size()) || stack_err !== m_err ||
          halted !== m_halt || imem_req !== !m_halt) begin
        errors++;
        $display("FAIL after_exec pc=%h depth=%0d err=%b halted=%b req=%b required pc=%h depth=%0d err=%b halted=%b req=%b",
                 pc, depth, stack_err, halted, imem_req, 4'(m_pc), stk.size(), m_err, m_halt, !m_halt);
      end
      cyc = 1;
    end
  endtask

  task automatic wait_exec(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); #1;
      if (exec_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit seen;
    clear_rom();
    rom[0] = 8'h80;
    do_reset();
    wait_exec(seen);
    @(negedge clk); #1;
    checks++;
    if (stack_err !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_err stack_err=%b required 1", stack_err);
    end
    wait_exec(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_wait_exec no exec_valid");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== pc || load !== 1'b1 || next_pc !== pc ||
        exec_valid !== 1'b0 || halted !== 1'b0 || depth !== 3'd0 ||
        stack_err !== 1'b0 || pc !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs req=%b addr=%h load=%b next_pc=%h ev=%b halted=%b depth=%0d err=%b pc=%h required 1 pc 1 pc 0 0 0 0 0",
               imem_req, imem_addr, load, next_pc, exec_valid, halted, depth, stack_err, pc);
    end
    @(negedge clk); #3 rst_n = 1'b1;
  endtask

  task automatic test_seq();
    clear_rom();
    run_prog(3);
    checks++;
    if (pc !== 4'd3 || n_exec != 3) begin
      errors++;
      $display("FAIL seq_run pc=%h execs=%0d required pc=3 execs=3", pc, n_exec);
    end
  endtask

  task automatic test_ack_delay();
    clear_rom();
    dly[1] = 3;
    run_prog(2);
    checks++;
    if (pc !== 4'd2) begin
      errors++;
      $display("FAIL ack_delay pc=%h required 2", pc);
    end
  endtask

  task automatic test_branch();
    clear_rom();
    rom[0]  = 8'h2A;
    rom[10] = 8'h43;
    zero_flag = 1'b0;
    run_prog(2);
    checks++;
    if (pc !== 4'hB) begin
      errors++;
      $display("FAIL jz_not_taken pc=%h required b", pc);
    end
    zero_flag = 1'b1;
    run_prog(2);
    checks++;
    if (pc !== 4'h3) begin
      errors++;
      $display("FAIL jz_taken pc=%h required 3", pc);
    end
    zero_flag = 1'b0;
  endtask

  task automatic test_call_ret();
    clear_rom();
    rom[0]  = 8'h2F;
    rom[15] = 8'h65;
    rom[5]  = 8'h80;
    run_prog(2);
    checks++;
    if (pc !== 4'h5 || depth !== 3'd1) begin
      errors++;
      $display("FAIL call_wrap pc=%h depth=%0d required pc=5 depth=1", pc, depth);
    end
    run_prog(3);
    checks++;
    if (pc !== 4'h0 || depth !== 3'd0 || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL ret_wrap pc=%h depth=%0d err=%b required pc=0 depth=0 err=0", pc, depth, stack_err);
    end
  endtask

  task automatic test_nested();
    clear_rom();
    rom[0] = 8'h62; rom[2] = 8'h64; rom[4] = 8'h66; rom[6] = 8'h68;
    rom[8] = 8'h6A;
    rom[10] = 8'h80; rom[7] = 8'h80; rom[5] = 8'h80; rom[3] = 8'h80; rom[1] = 8'h80;
    run_prog(5);
    checks++;
    if (pc !== 4'hA || depth !== 3'd4 || stack_err !== 1'b1) begin
      errors++;
      $display("FAIL stack_overflow pc=%h depth=%0d err=%b required pc=a depth=4 err=1", pc, depth, stack_err);
    end
    run_prog(10);
    checks++;
    if (pc !== 4'h2 || depth !== 3'd0 || stack_err !== 1'b1 || n_exec != 10) begin
      errors++;
      $display("FAIL stack_unwind pc=%h depth=%0d err=%b execs=%0d required pc=2 depth=0 err=1 execs=10",
               pc, depth, stack_err, n_exec);
    end
  endtask

  task automatic test_halt();
    bit seen;
    clear_rom();
    rom[0] = 8'h80;
    rom[3] = 8'hA0;
    run_prog(4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if (pc !== 4'h3 || halted !== 1'b1 || imem_req !== 1'b0 || exec_valid !== 1'b0 ||
          load !== 1'b1 || next_pc !== 4'h3) begin
        errors++;
        $display("FAIL halt_hold pc=%h halted=%b req=%b ev=%b load=%b next_pc=%h required pc=3 1 0 0 1 3",
                 pc, halted, imem_req, exec_valid, load, next_pc);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 4'h0 || halted !== 1'b0 || imem_req !== 1'b1 || stack_err !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset pc=%h halted=%b req=%b err=%b required pc=0 halted=0 req=1 err=0",
               pc, halted, imem_req, stack_err);
    end
    @(negedge clk); #3 rst_n = 1'b1;
    wait_exec(seen);
    checks++;
    if (!seen || pc !== 4'h0) begin
      errors++;
      $display("FAIL halt_resume seen=%b pc=%h required seen=1 pc=0", seen, pc);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 16; i++) begin
        rom[i] = 8'($urandom);
        dly[i] = int'($urandom_range(0, 3));
      end
      zero_flag = 1'($urandom);
      run_prog(12);
    end
    zero_flag = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_rom();
    test_reset();
    test_seq();
    test_ack_delay();
    test_branch();
    test_call_ret();
    test_nested();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
